// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver (1 start bit, BITS_PER_WORD data bits
// LSB-first, STOP_BITS stop bits) feeding a one-entry valid/ready output buffer.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx #(
  parameter int CLOCKS_PER_PULSE = 5208,
  parameter int BITS_PER_WORD    = 8,
  parameter int STOP_BITS        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = $clog2(BITS_PER_WORD + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(BITS_PER_WORD - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t                   state_r;
  state_t                   state_s;
  logic                     rx_meta_r;
  logic                     rx_s_r;
  logic                     line_high_r;
  logic [CW-1:0]            c_clocks_r;
  logic [BW-1:0]            c_bits_r;
  logic [BITS_PER_WORD-1:0] shift_r;
  logic                     stop_err_r;
  logic                     done_r;
  logic                     done_err_r;

  logic half_tick_s;
  logic bit_tick_s;
  logic last_data_s;
  logic last_stop_s;
  logic start_ok_s;
  logic mid_start_s;
  logic sample_data_s;
  logic sample_stop_s;
  logic frame_end_s;

  assign half_tick_s = (c_clocks_r == HALF_LAST);
  assign bit_tick_s  = (c_clocks_r == BIT_LAST);
  assign last_data_s = (c_bits_r == DATA_LAST);
  assign last_stop_s = (c_bits_r == STOP_LAST);

  // Two-flop synchroniser for the asynchronous rx pin; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s_r    <= rx_meta_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_s = ST_START;
        else            state_s = ST_IDLE;
      end
      ST_START: begin
        if (mid_start_s) state_s = rx_s_r ? ST_IDLE : ST_DATA;
        else             state_s = ST_START;
      end
      ST_DATA: begin
        if (sample_data_s && last_data_s) state_s = ST_STOP;
        else                              state_s = ST_DATA;
      end
      ST_STOP: begin
        if (frame_end_s) state_s = ST_IDLE;
        else             state_s = ST_STOP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM output decode: per-state strobes that drive the datapath.
  always_comb begin
    start_ok_s    = 1'b0;
    mid_start_s   = 1'b0;
    sample_data_s = 1'b0;
    sample_stop_s = 1'b0;
    frame_end_s   = 1'b0;
    case (state_r)
      ST_IDLE:  start_ok_s    = !rx_s_r && line_high_r;
      ST_START: mid_start_s   = half_tick_s;
      ST_DATA:  sample_data_s = bit_tick_s;
      ST_STOP: begin
        sample_stop_s = bit_tick_s;
        frame_end_s   = bit_tick_s && last_stop_s;
      end
      default: start_ok_s = 1'b0;
    endcase
  end

  // Bit timing, shift register, stop-bit error latch and the "line seen high"
  // qualifier that makes IDLE wait for a genuine falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_clocks_r  <= '0;
      c_bits_r    <= '0;
      shift_r     <= '0;
      stop_err_r  <= 1'b0;
      line_high_r <= 1'b0;
      done_r      <= 1'b0;
      done_err_r  <= 1'b0;
    end else begin
      done_r     <= frame_end_s;
      done_err_r <= stop_err_r | ~rx_s_r;
      case (state_r)
        ST_IDLE: begin
          c_clocks_r <= '0;
          c_bits_r   <= '0;
          if (start_ok_s)  line_high_r <= 1'b0;
          else if (rx_s_r) line_high_r <= 1'b1;
          else             line_high_r <= line_high_r;
        end
        ST_START: begin
          if (mid_start_s) begin
            c_clocks_r <= '0;
            c_bits_r   <= '0;
            stop_err_r <= 1'b0;
          end else begin
            c_clocks_r <= c_clocks_r + CW'(1);
          end
        end
        ST_DATA: begin
          if (sample_data_s) begin
            c_clocks_r <= '0;
            shift_r    <= {rx_s_r, shift_r[BITS_PER_WORD-1:1]};
            c_bits_r   <= last_data_s ? BW'(0) : c_bits_r + BW'(1);
          end else begin
            c_clocks_r <= c_clocks_r + CW'(1);
          end
        end
        ST_STOP: begin
          if (sample_stop_s) begin
            c_clocks_r <= '0;
            c_bits_r   <= last_stop_s ? BW'(0) : c_bits_r + BW'(1);
            if (!rx_s_r) stop_err_r <= 1'b1;
            // A high final stop sample lets the next start edge be taken at once.
            if (frame_end_s) line_high_r <= rx_s_r;
          end else begin
            c_clocks_r <= c_clocks_r + CW'(1);
          end
        end
        default: begin
          c_clocks_r <= '0;
          c_bits_r   <= '0;
        end
      endcase
    end
  end

  // One-entry output buffer plus error/overrun pulses; framing error wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (done_r && done_err_r) begin
        frame_err <= 1'b1;
        if (m_valid && m_ready) m_valid <= 1'b0;
      end else if (done_r && m_valid && !m_ready) begin
        overrun <= 1'b1;
      end else if (done_r) begin
        m_data  <= shift_r;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (16 clocks per bit, 2 stop bits).
module tb_uart_rx;

  localparam int CPP = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_valid;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int lat1 = 171;

  // monitor state
  int         rise_cnt = 0;
  int         rise_cyc = 0;
  int         valid_cyc = 0;
  int         fe_cnt = 0;
  int         fe_wide = 0;
  int         ov_cnt = 0;
  int         both_cnt = 0;
  int         got_n = 0;
  logic [7:0] got [0:63];
  logic       prev_valid = 1'b0;
  logic       prev_fe = 1'b0;

  uart_rx #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .STOP_BITS(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_fe    <= 1'b0;
    end else begin
      prev_valid <= m_valid;
      prev_fe    <= frame_err;
      if (m_valid && !prev_valid) begin
        rise_cnt <= rise_cnt + 1;
        rise_cyc <= cyc;
      end
      if (m_valid) valid_cyc <= valid_cyc + 1;
      if (m_valid && m_ready) begin
        got[got_n] <= m_data;
        got_n <= got_n + 1;
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (frame_err && prev_fe) fe_wide <= fe_wide + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
      if (overrun && frame_err) both_cnt <= both_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPP) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic s0, input logic s1);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(s0);
    send_bit(s1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h expected %h", m_data, 8'h00); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected %b", m_valid, 1'b0); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected %b", frame_err, 1'b0); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected %b", overrun, 1'b0); end
    rst = 1'b0;
    idle(5);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle_valid: got %b expected %b", m_valid, 1'b0); end
  endtask

  task automatic test_single_frame;
    int rd, r0, v0, f0, o0, lat;
    rd = got_n; r0 = rise_cnt; v0 = valid_cyc; f0 = fe_cnt; o0 = ov_cnt;
    m_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(4);
    lat = rise_cyc - fall_cyc;
    n_checks++; if (rise_cnt - r0 !== 1) begin n_fail++; $display("FAIL single_valid_rises: got %0d expected %0d", rise_cnt - r0, 1); end
    n_checks++; if (valid_cyc - v0 !== 1) begin n_fail++; $display("FAIL single_valid_width: got %0d expected %0d", valid_cyc - v0, 1); end
    n_checks++; if (got_n - rd !== 1) begin n_fail++; $display("FAIL single_word_count: got %0d expected %0d", got_n - rd, 1); end
    n_checks++; if (got[rd] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected %h", got[rd], 8'hA5); end
    n_checks++; if (fe_cnt - f0 !== 0) begin n_fail++; $display("FAIL single_frame_err: got %0d expected %0d", fe_cnt - f0, 0); end
    n_checks++; if (ov_cnt - o0 !== 0) begin n_fail++; $display("FAIL single_overrun: got %0d expected %0d", ov_cnt - o0, 0); end
    n_checks++; if (lat < 170 || lat > 173) begin n_fail++; $display("FAIL single_latency: got %0d expected 170..173", lat); end
    else lat1 = lat;
  endtask

  task automatic test_glitch;
    int rd, r0, f0;
    rd = got_n; r0 = rise_cnt; f0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    n_checks++; if (rise_cnt - r0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected %0d", rise_cnt - r0, 0); end
    n_checks++; if (fe_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d expected %0d", fe_cnt - f0, 0); end
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(4);
    n_checks++; if (got_n - rd !== 1) begin n_fail++; $display("FAIL glitch_next_count: got %0d expected %0d", got_n - rd, 1); end
    n_checks++; if (got[rd] !== 8'h3C) begin n_fail++; $display("FAIL glitch_next_data: got %h expected %h", got[rd], 8'h3C); end
  endtask

  task automatic test_frame_error;
    int r0, f0, w0, o0;
    r0 = rise_cnt; f0 = fe_cnt; w0 = fe_wide; o0 = ov_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(4);
    n_checks++; if (fe_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d expected %0d", fe_cnt - f0, 1); end
    n_checks++; if (fe_wide - w0 !== 0) begin n_fail++; $display("FAIL ferr_width: got %0d extra cycles expected %0d", fe_wide - w0, 0); end
    n_checks++; if (rise_cnt - r0 !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d expected %0d", rise_cnt - r0, 0); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid_now: got %b expected %b", m_valid, 1'b0); end
    n_checks++; if (ov_cnt - o0 !== 0) begin n_fail++; $display("FAIL ferr_overrun: got %0d expected %0d", ov_cnt - o0, 0); end
  endtask

  task automatic test_overrun;
    int rd, f0, o0, b0;
    rd = got_n; f0 = fe_cnt; o0 = ov_cnt; b0 = both_cnt;
    m_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    idle(4);
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %b expected %b", m_valid, 1'b1); end
    n_checks++; if (m_data !== 8'h11) begin n_fail++; $display("FAIL ovr_first_data: got %h expected %h", m_data, 8'h11); end
    send_frame(8'h22, 1'b1, 1'b1);
    idle(4);
    n_checks++; if (m_data !== 8'h11) begin n_fail++; $display("FAIL ovr_held_data: got %h expected %h", m_data, 8'h11); end
    n_checks++; if (ov_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected %0d", ov_cnt - o0, 1); end
    n_checks++; if (fe_cnt - f0 !== 0) begin n_fail++; $display("FAIL ovr_frame_err: got %0d expected %0d", fe_cnt - f0, 0); end
    n_checks++; if (both_cnt - b0 !== 0) begin n_fail++; $display("FAIL ovr_both_flags: got %0d expected %0d", both_cnt - b0, 0); end
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain_valid: got %b expected %b", m_valid, 1'b0); end
    n_checks++; if (got_n - rd !== 1) begin n_fail++; $display("FAIL ovr_drain_count: got %0d expected %0d", got_n - rd, 1); end
    n_checks++; if (got[rd] !== 8'h11) begin n_fail++; $display("FAIL ovr_drain_data: got %h expected %h", got[rd], 8'h11); end
  endtask

  task automatic test_back_to_back;
    int rd, f0, o0;
    rd = got_n; f0 = fe_cnt; o0 = ov_cnt;
    m_ready = 1'b1;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    idle(4);
    n_checks++; if (got_n - rd !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", got_n - rd, 3); end
    n_checks++; if (got[rd] !== 8'h00) begin n_fail++; $display("FAIL b2b_word0: got %h expected %h", got[rd], 8'h00); end
    n_checks++; if (got[rd+1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_word1: got %h expected %h", got[rd+1], 8'hFF); end
    n_checks++; if (got[rd+2] !== 8'h80) begin n_fail++; $display("FAIL b2b_word2: got %h expected %h", got[rd+2], 8'h80); end
    n_checks++; if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin n_fail++; $display("FAIL b2b_flags: got %0d expected %0d", (fe_cnt - f0) + (ov_cnt - o0), 0); end
    // Drain on the exact completion cycle of the next word.
    m_ready = 1'b0;
    send_frame(8'h66, 1'b1, 1'b1);
    idle(4);
    n_checks++; if (m_data !== 8'h66) begin n_fail++; $display("FAIL b2b_hold_data: got %h expected %h", m_data, 8'h66); end
    rd = got_n; o0 = ov_cnt;
    fork
      send_frame(8'h99, 1'b1, 1'b1);
      begin
        repeat (lat1 - 1) @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
      end
    join
    idle(4);
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_exact_valid: got %b expected %b", m_valid, 1'b1); end
    n_checks++; if (m_data !== 8'h99) begin n_fail++; $display("FAIL b2b_exact_data: got %h expected %h", m_data, 8'h99); end
    n_checks++; if (ov_cnt - o0 !== 0) begin n_fail++; $display("FAIL b2b_exact_overrun: got %0d expected %0d", ov_cnt - o0, 0); end
    n_checks++; if (got_n - rd !== 1 || got[rd] !== 8'h66) begin n_fail++; $display("FAIL b2b_exact_consumed: got %0d words first %h expected 1 word 66", got_n - rd, got[rd]); end
  endtask

  task automatic test_reset_midframe;
    int rd, f0, o0;
    logic [7:0] d;
    d = 8'h5A;
    f0 = fe_cnt; o0 = ov_cnt;
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b expected %b", m_valid, 1'b1); end
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rx = d[3];
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected %b", m_valid, 1'b0); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h expected %h", m_data, 8'h00); end
    n_checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got %b%b expected 00", frame_err, overrun); end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_ready = 1'b1;
    idle(5);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_after_valid: got %b expected %b", m_valid, 1'b0); end
    rd = got_n;
    send_frame(8'hC3, 1'b1, 1'b1);
    idle(4);
    n_checks++; if (got_n - rd !== 1) begin n_fail++; $display("FAIL rstmid_next_count: got %0d expected %0d", got_n - rd, 1); end
    n_checks++; if (got[rd] !== 8'hC3) begin n_fail++; $display("FAIL rstmid_next_data: got %h expected %h", got[rd], 8'hC3); end
    n_checks++; if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin n_fail++; $display("FAIL rstmid_no_flags: got %0d expected %0d", (fe_cnt - f0) + (ov_cnt - o0), 0); end
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_single_frame;
    test_glitch;
    test_frame_error;
    test_overrun;
    test_back_to_back;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
